adma_ram_responder: RTL and testbench

Word-addressed synchronous RAM responder that sits on the ADMA system-memory port and answers the address/write/read/data strobes issued by the ADMA engine and its stimulus modules. It accepts 64-bit byte addresses, stores 32-bit words, returns registered read data with a valid strobe, and flags illegal accesses. An optional wait-state engine, selected at compile time, models slow system memory with a ready handshake.

---
 rtl/adma_ram_responder.sv | 159 +++++++++++++++
 tb/tb_adma_ram_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_ram_responder.sv
// Word-addressed RAM responder for the ADMA system-memory port, with address-window and alignment checks.
// Define ADMA_RAM_WAIT_EN to compile in the wait-state engine (ready handshake, WAIT_CYCLES per access).
//
// state  | meaning
// S_IDLE | ready=1, waiting for a read or write strobe
// S_WAIT | request latched, counting wait-state edges
// S_DONE | result produced on the entry edge, recovery cycle before ready returns
`timescale 1ns/1ps
module adma_ram_responder #(
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int          DEPTH       = 256,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [63:0] address,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        ready,
   output logic        error
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [64:0] WIN_END = {1'b0, BASE_ADDR} + (65'(DEPTH) << 2);

   function automatic logic addr_legal(input logic [63:0] a);
      return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, a} < WIN_END);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
      return AW'((a - BASE_ADDR) >> 2);
   endfunction

   logic [31:0]   mem [DEPTH];

   // The commit port: one request resolved per cycle when c_en is high.
   logic          c_en;
   logic          c_wr;
   logic          c_rd;
   logic [63:0]   c_addr;
   logic [31:0]   c_data;
   logic          c_ok;
   logic [AW-1:0] c_idx;

   assign c_ok  = addr_legal(c_addr) && !(c_wr && c_rd);
   assign c_idx = word_idx(c_addr);

`ifdef ADMA_RAM_WAIT_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [63:0] req_addr;
   logic [31:0] req_data;
   logic        req_wr;
   logic        req_rd;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= S_IDLE;
         ready    <= 1'b1;
         wait_cnt <= 4'd0;
         req_addr <= 64'd0;
         req_data <= 32'd0;
         req_wr   <= 1'b0;
         req_rd   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (write || read) begin
                  req_addr <= address;
                  req_data <= data_in;
                  req_wr   <= write;
                  req_rd   <= read;
                  ready    <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_DONE;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // With zero wait states the request resolves on the accepting edge from the live inputs.
   always_comb begin
      c_en   = (state == S_WAIT) && (wait_cnt == 4'd0);
      c_wr   = req_wr;
      c_rd   = req_rd;
      c_addr = req_addr;
      c_data = req_data;
      if ((WAIT_CYCLES == 0) && (state == S_IDLE)) begin
         c_en   = write || read;
         c_wr   = write;
         c_rd   = read;
         c_addr = address;
         c_data = data_in;
      end
   end
`else
   logic [3:0] unused_cfg;

   assign unused_cfg = 4'(WAIT_CYCLES);
   assign ready      = 1'b1;
   assign c_en       = write || read;
   assign c_wr       = write;
   assign c_rd       = read;
   assign c_addr     = address;
   assign c_data     = data_in;
`endif

   // Storage is intentionally not reset so contents survive RESET_N.
   always_ff @(posedge CLK) begin
      if (c_en && c_ok && c_wr) begin
         mem[c_idx] <= c_data;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         data_out   <= 32'd0;
         data_valid <= 1'b0;
         error      <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         error      <= 1'b0;
         if (c_en) begin
            if (!c_ok) begin
               error <= 1'b1;
            end else if (c_rd) begin
               data_out   <= mem[c_idx];
               data_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adma_ram_responder.sv
// Self-checking bench for adma_ram_responder: two instances (window at 0 and at 512) against a
// behavioural memory model; extra wait-state and reset-mid-access steps when ADMA_RAM_WAIT_EN is set.
`timescale 1ns/1ps
module tb_adma_ram_responder;

`ifdef ADMA_RAM_WAIT_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam logic [63:0] BASE0 = 64'd0;
   localparam logic [63:0] BASE1 = 64'd512;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] address;
   logic [31:0] data_in;
   logic        write_s [2];
   logic        read_s  [2];
   logic [31:0] dout_s  [2];
   logic        valid_s [2];
   logic        ready_s [2];
   logic        err_s   [2];

   always #5 clk = ~clk;

   adma_ram_responder #(.BASE_ADDR(BASE0), .DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .address(address), .write(write_s[0]), .read(read_s[0]),
      .data_in(data_in), .data_out(dout_s[0]), .data_valid(valid_s[0]), .ready(ready_s[0]),
      .error(err_s[0]));

   adma_ram_responder #(.BASE_ADDR(BASE1), .DEPTH(256), .WAIT_CYCLES(2)) u_dut1 (
      .CLK(clk), .RESET_N(rst_n), .address(address), .write(write_s[1]), .read(read_s[1]),
      .data_in(data_in), .data_out(dout_s[1]), .data_valid(valid_s[1]), .ready(ready_s[1]),
      .error(err_s[1]));

   logic [31:0] mm [2][256];
   logic [31:0] m_dout [2];
   int          wq [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One access on instance sel; expectations come from the window/alignment rules applied to the model.
   task automatic access(input int sel, input logic [63:0] a, input logic w, input logic r,
                         input logic [31:0] d, input string tag);
      logic [63:0] b;
      logic        legal;
      logic [7:0]  idx;
      logic        exp_v;
      logic        exp_e;
      int          n;
      b     = (sel == 0) ? BASE0 : BASE1;
      legal = !(w && r) && (a[1:0] == 2'b00) && (a >= b) && (a < b + 64'd1024);
      idx   = 8'((a - b) / 64'd4);
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (w || r) begin
         if (!legal) begin
            exp_e = 1'b1;
         end else if (r) begin
            exp_v        = 1'b1;
            m_dout[sel]  = mm[sel][idx];
         end else begin
            mm[sel][idx] = d;
            if (sel == 0) wq.push_back(int'(idx));
         end
      end
      @(negedge clk);
      n = 0;
      while (ready_s[sel] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/ready"}, 64'(ready_s[sel]), 64'd1);
      address      = a;
      data_in      = d;
      write_s[sel] = w;
      read_s[sel]  = r;
      @(posedge clk);
      #1;
      write_s[sel] = 1'b0;
      read_s[sel]  = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         @(posedge clk);
         #1;
      end
      chk({tag, "/valid"}, 64'(valid_s[sel]), 64'(exp_v));
      chk({tag, "/error"}, 64'(err_s[sel]), 64'(exp_e));
      chk({tag, "/data"}, 64'(dout_s[sel]), 64'(m_dout[sel]));
      @(posedge clk);
      #1;
      chk({tag, "/pulse"}, {62'd0, valid_s[sel], err_s[sel]}, 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int s = 0; s < 2; s++) begin
         chk({tag, "/dout"}, 64'(dout_s[s]), 64'd0);
         chk({tag, "/valid"}, 64'(valid_s[s]), 64'd0);
         chk({tag, "/error"}, 64'(err_s[s]), 64'd0);
         chk({tag, "/ready"}, 64'(ready_s[s]), 64'd1);
      end
   endtask

   initial begin
      int          vcount;
      int          op;
      logic [63:0] ra;
      logic [31:0] rd;
      rst_n      = 1'b0;
      address    = 64'd0;
      data_in    = 32'd0;
      write_s[0] = 1'b0;
      write_s[1] = 1'b0;
      read_s[0]  = 1'b0;
      read_s[1]  = 1'b0;
      m_dout[0]  = 32'd0;
      m_dout[1]  = 32'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 1; i <= 24; i++) access(0, 64'(4 * i), 1'b1, 1'b0, 32'(4 * i), "seq_wr");
      for (int i = 1; i <= 24; i++) access(0, 64'(4 * i), 1'b0, 1'b1, 32'd0, "seq_rd");

`ifdef ADMA_RAM_WAIT_EN
      access(0, 64'h40, 1'b1, 1'b0, 32'hDEAD_BEEF, "raw_wr");
      access(0, 64'h40, 1'b0, 1'b1, 32'd0, "raw_rd");
`else
      @(negedge clk);
      address    = 64'h40;
      data_in    = 32'hDEAD_BEEF;
      write_s[0] = 1'b1;
      @(negedge clk);
      write_s[0] = 1'b0;
      read_s[0]  = 1'b1;
      @(negedge clk);
      read_s[0]  = 1'b0;
      mm[0][16]  = 32'hDEAD_BEEF;
      m_dout[0]  = 32'hDEAD_BEEF;
      chk("raw/valid", 64'(valid_s[0]), 64'd1);
      chk("raw/data", 64'(dout_s[0]), 64'hDEAD_BEEF);
      @(negedge clk);
      chk("raw/pulse", 64'(valid_s[0]), 64'd0);
`endif

      access(0, 64'h42, 1'b0, 1'b1, 32'd0, "ill_misaligned");
      access(0, 64'd1024, 1'b0, 1'b1, 32'd0, "ill_window_end");
      access(0, 64'h10, 1'b1, 1'b1, 32'hFFFF_FFFF, "ill_both");
      access(0, 64'h10, 1'b0, 1'b1, 32'd0, "mem4_kept");
      access(0, 64'd1020, 1'b1, 1'b0, 32'hCAFE_0001, "last_wr");
      access(0, 64'd1020, 1'b0, 1'b1, 32'd0, "last_rd");

      access(1, 64'd512, 1'b1, 1'b0, 32'h11, "win_wr");
      access(1, 64'd512, 1'b0, 1'b1, 32'd0, "win_rd");
      access(1, 64'd508, 1'b0, 1'b1, 32'd0, "win_below");
      access(1, 64'd1536, 1'b0, 1'b1, 32'd0, "win_above");

      @(negedge clk);
      rst_n = 1'b0;
      m_dout[0] = 32'd0;
      m_dout[1] = 32'd0;
      #1;
      check_reset_outputs("reset2");
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 64'h40, 1'b0, 1'b1, 32'd0, "survive_rd");
      access(1, 64'd512, 1'b0, 1'b1, 32'd0, "survive_rd1");

`ifdef ADMA_RAM_WAIT_EN
      vcount = 0;
      @(negedge clk);
      address   = 64'h40;
      read_s[0] = 1'b1;
      m_dout[0] = mm[0][16];
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (valid_s[0]) vcount++;
         chk($sformatf("wait/ready_c%0d", c), 64'(ready_s[0]), 64'(c == 4));
         chk($sformatf("wait/valid_c%0d", c), 64'(valid_s[0]), 64'(c == 3));
      end
      read_s[0] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (valid_s[0]) vcount++;
      end
      chk("wait/one_access", 64'(vcount), 64'd1);
      chk("wait/data", 64'(dout_s[0]), 64'(m_dout[0]));

      @(negedge clk);
      address    = 64'h20;
      data_in    = 32'h55;
      write_s[0] = 1'b1;
      @(posedge clk);
      #1;
      write_s[0] = 1'b0;
      @(negedge clk);
      chk("rstmid/busy", 64'(ready_s[0]), 64'd0);
      rst_n = 1'b0;
      m_dout[0] = 32'd0;
      m_dout[1] = 32'd0;
      #1;
      chk("rstmid/ready", 64'(ready_s[0]), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rstmid/quiet", {62'd0, valid_s[0], err_s[0]}, 64'd0);
      end
      access(0, 64'h20, 1'b0, 1'b1, 32'd0, "rstmid_rd");
`endif

      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 3));
         rd = $urandom;
         case (op)
            0: begin
               ra = 64'(4 * $urandom_range(0, 255));
               access(0, ra, 1'b1, 1'b0, rd, "rnd_wr");
            end
            1: begin
               ra = 64'(4 * wq[$urandom_range(0, wq.size() - 1)]);
               access(0, ra, 1'b0, 1'b1, 32'd0, "rnd_rd");
            end
            2: begin
               ra = 64'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
               access(0, ra, $urandom_range(0, 1) == 1, 1'b1, rd, "rnd_misaligned");
            end
            default: begin
               ra = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                : 64'd1024 + 64'(4 * $urandom_range(0, 4095));
               access(0, ra, 1'b0, 1'b1, 32'd0, "rnd_window");
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
